// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: sequential advance, branch/jump redirect
// with post-redirect bubbles, hazard stalls and halt.
module pc_sequencer #(
  parameter int unsigned             WIDTH            = 32,
  parameter logic [WIDTH-1:0]        RESET_PC         = '0,
  parameter int unsigned             REDIRECT_BUBBLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic [WIDTH-1:0] branch_pc_i,
  input  logic [WIDTH-1:0] branch_imm_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic             halt_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             fetch_valid_o,
  output logic             flush_o,
  output logic             halted_o,
  output logic [15:0]      redirect_count_o
);

  localparam int unsigned BubW = 3;
  localparam int unsigned CntW = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_BUBBLE,
    S_HALTED
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  pc_q, pc_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              halted_q, halted_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [BubW-1:0]   bubble_q, bubble_d;
  logic [WIDTH-1:0]  target_c;
  logic              redirect_c;

  // Jump wins over a simultaneous branch; offsets are in words, carry dropped.
  assign target_c   = jump_i ? jump_target_i : (branch_pc_i + WIDTH'(1) + branch_imm_i);
  assign redirect_c = jump_i | branch_taken_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      count_q       <= '0;
      bubble_q      <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      halted_q      <= halted_d;
      count_q       <= count_d;
      bubble_q      <= bubble_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_valid_d = fetch_valid_q;
    halted_d      = halted_q;
    count_d       = count_q;
    bubble_d      = bubble_q;
    flush_o       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        state_d       = S_RUN;
        fetch_valid_d = 1'b1;
      end
      S_RUN, S_BUBBLE: begin
        if (halt_i) begin
          state_d       = S_HALTED;
          fetch_valid_d = 1'b0;
          halted_d      = 1'b1;
        end else if (redirect_c) begin
          flush_o = 1'b1;
          pc_d    = target_c;
          count_d = (count_q == {CntW{1'b1}}) ? count_q : count_q + CntW'(1);
          if (REDIRECT_BUBBLES == 0) begin
            state_d       = S_RUN;
            fetch_valid_d = 1'b1;
          end else begin
            state_d       = S_BUBBLE;
            fetch_valid_d = 1'b0;
            bubble_d      = BubW'(REDIRECT_BUBBLES);
          end
        end else if (state_q == S_BUBBLE) begin
          // Bubble countdown ignores stall; last bubble cycle releases fetch.
          bubble_d = bubble_q - BubW'(1);
          if (bubble_q <= BubW'(1)) begin
            state_d       = S_RUN;
            fetch_valid_d = 1'b1;
            bubble_d      = '0;
          end
        end else if (!stall_i) begin
          pc_d = pc_q + WIDTH'(1);
        end
      end
      S_HALTED: begin
        fetch_valid_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pc_o             = pc_q;
  assign fetch_valid_o    = fetch_valid_q;
  assign halted_o         = halted_q;
  assign redirect_count_o = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one instance with a single redirect bubble,
// one with three bubbles, driven by shared stimulus.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_taken, jump, halt;
  logic [31:0] branch_pc, branch_imm, jump_target;

  logic [31:0] pc1, pc3;
  logic        fv1, fv3, fl1, fl3, hl1, hl3;
  logic [15:0] rc1, rc3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.WIDTH(32), .RESET_PC(32'h0), .REDIRECT_BUBBLES(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .branch_taken_i(branch_taken),
    .branch_pc_i(branch_pc), .branch_imm_i(branch_imm), .jump_i(jump),
    .jump_target_i(jump_target), .halt_i(halt), .pc_o(pc1), .fetch_valid_o(fv1),
    .flush_o(fl1), .halted_o(hl1), .redirect_count_o(rc1)
  );

  pc_sequencer #(.WIDTH(32), .RESET_PC(32'h0), .REDIRECT_BUBBLES(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .branch_taken_i(branch_taken),
    .branch_pc_i(branch_pc), .branch_imm_i(branch_imm), .jump_i(jump),
    .jump_target_i(jump_target), .halt_i(halt), .pc_o(pc3), .fetch_valid_o(fv3),
    .flush_o(fl3), .halted_o(hl3), .redirect_count_o(rc3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; halt = 1'b0;
    branch_pc = '0; branch_imm = '0; jump_target = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #12;
    n_checks++; if (pc1 !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want %h", pc1, 32'h0); end
    n_checks++; if (fv1 !== 1'b0) begin n_fail++; $display("FAIL reset_fv got %b want 0", fv1); end
    n_checks++; if (hl1 !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", hl1); end
    n_checks++; if (rc1 !== 16'h0) begin n_fail++; $display("FAIL reset_count got %h want 0", rc1); end
    n_checks++; if (fl1 !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b want 0", fl1); end
    step();
    rst_n = 1'b1;
    #1;
    n_checks++; if (pc1 !== 32'h0 || fv1 !== 1'b0) begin n_fail++; $display("FAIL release_c0 got pc=%h fv=%b want pc=0 fv=0", pc1, fv1); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (pc1 !== 32'(i) || fv1 !== 1'b1) begin
        n_fail++; $display("FAIL idle_seq[%0d] got pc=%h fv=%b want pc=%h fv=1", i, pc1, fv1, 32'(i));
      end
    end
  endtask

  task automatic test_branch();
    step(); step();
    n_checks++; if (pc1 !== 32'd5) begin n_fail++; $display("FAIL pre_branch_pc got %h want 5", pc1); end
    branch_taken = 1'b1; branch_pc = 32'd3; branch_imm = 32'd10;
    #1;
    n_checks++; if (fl1 !== 1'b1) begin n_fail++; $display("FAIL branch_flush got %b want 1", fl1); end
    step();
    clear_inputs();
    #1;
    n_checks++; if (fl1 !== 1'b0) begin n_fail++; $display("FAIL flush_drop got %b want 0", fl1); end
    n_checks++; if (pc1 !== 32'd14 || fv1 !== 1'b0) begin n_fail++; $display("FAIL branch_bubble got pc=%h fv=%b want pc=e fv=0", pc1, fv1); end
    n_checks++; if (rc1 !== 16'd1) begin n_fail++; $display("FAIL branch_count got %h want 1", rc1); end
    step();
    n_checks++; if (pc1 !== 32'd14 || fv1 !== 1'b1) begin n_fail++; $display("FAIL branch_target got pc=%h fv=%b want pc=e fv=1", pc1, fv1); end
    step();
    n_checks++; if (pc1 !== 32'd15 || fv1 !== 1'b1) begin n_fail++; $display("FAIL branch_next got pc=%h fv=%b want pc=f fv=1", pc1, fv1); end
  endtask

  task automatic test_negative_and_wrap();
    branch_taken = 1'b1; branch_pc = 32'd8; branch_imm = 32'hFFFF_FFFC;
    step();
    clear_inputs();
    n_checks++; if (pc1 !== 32'd5 || fv1 !== 1'b0) begin n_fail++; $display("FAIL neg_branch got pc=%h fv=%b want pc=5 fv=0", pc1, fv1); end
    step();
    n_checks++; if (pc1 !== 32'd5 || fv1 !== 1'b1) begin n_fail++; $display("FAIL neg_valid got pc=%h fv=%b want pc=5 fv=1", pc1, fv1); end
    jump = 1'b1; jump_target = 32'hFFFF_FFFF;
    step();
    clear_inputs();
    step();
    n_checks++; if (pc1 !== 32'hFFFF_FFFF || fv1 !== 1'b1) begin n_fail++; $display("FAIL wrap_pre got pc=%h fv=%b want pc=ffffffff fv=1", pc1, fv1); end
    step();
    n_checks++; if (pc1 !== 32'h0 || fv1 !== 1'b1) begin n_fail++; $display("FAIL wrap_zero got pc=%h fv=%b want pc=0 fv=1", pc1, fv1); end
    n_checks++; if (rc1 !== 16'd3) begin n_fail++; $display("FAIL wrap_count got %h want 3", rc1); end
  endtask

  task automatic test_jump_priority_stall();
    jump = 1'b1; jump_target = 32'h40; branch_taken = 1'b1; branch_pc = 32'h100; stall = 1'b1;
    #1;
    n_checks++; if (fl1 !== 1'b1) begin n_fail++; $display("FAIL jump_flush got %b want 1", fl1); end
    step();
    clear_inputs();
    n_checks++; if (pc1 !== 32'h40) begin n_fail++; $display("FAIL jump_wins got %h want 40", pc1); end
    n_checks++; if (rc1 !== 16'd4) begin n_fail++; $display("FAIL jump_count_once got %h want 4", rc1); end
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (pc1 !== 32'h40 || fv1 !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d] got pc=%h fv=%b want pc=40 fv=1", i, pc1, fv1);
      end
    end
    stall = 1'b0;
    step();
    n_checks++; if (pc1 !== 32'h41) begin n_fail++; $display("FAIL stall_release got %h want 41", pc1); end
  endtask

  task automatic test_halt();
    halt = 1'b1; jump = 1'b1; jump_target = 32'h100;
    #1;
    n_checks++; if (fl1 !== 1'b0) begin n_fail++; $display("FAIL halt_flush got %b want 0", fl1); end
    step();
    halt = 1'b0;
    n_checks++; if (hl1 !== 1'b1 || fv1 !== 1'b0 || pc1 !== 32'h41) begin
      n_fail++; $display("FAIL halt_enter got halted=%b fv=%b pc=%h want 1 0 41", hl1, fv1, pc1);
    end
    step(); step();
    n_checks++; if (pc1 !== 32'h41 || rc1 !== 16'd4 || fl1 !== 1'b0 || hl1 !== 1'b1) begin
      n_fail++; $display("FAIL halt_ignore got pc=%h cnt=%h flush=%b halted=%b want 41 4 0 1", pc1, rc1, fl1, hl1);
    end
    clear_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (pc1 !== 32'h0 || hl1 !== 1'b0 || fv1 !== 1'b0 || rc1 !== 16'h0) begin
      n_fail++; $display("FAIL async_reset got pc=%h halted=%b fv=%b cnt=%h want 0 0 0 0", pc1, hl1, fv1, rc1);
    end
  endtask

  task automatic test_back_to_back();
    step();
    rst_n = 1'b1;
    step();
    n_checks++; if (pc3 !== 32'h0 || fv3 !== 1'b1) begin n_fail++; $display("FAIL b3_run got pc=%h fv=%b want 0 1", pc3, fv3); end
    jump = 1'b1; jump_target = 32'h200;
    step();
    clear_inputs();
    n_checks++; if (pc3 !== 32'h200 || fv3 !== 1'b0) begin n_fail++; $display("FAIL b3_bub1 got pc=%h fv=%b want 200 0", pc3, fv3); end
    step();
    n_checks++; if (pc3 !== 32'h200 || fv3 !== 1'b0) begin n_fail++; $display("FAIL b3_bub2 got pc=%h fv=%b want 200 0", pc3, fv3); end
    jump = 1'b1; jump_target = 32'h300;
    #1;
    n_checks++; if (fl3 !== 1'b1) begin n_fail++; $display("FAIL b3_flush got %b want 1", fl3); end
    step();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (pc3 !== 32'h300 || fv3 !== 1'b0) begin
        n_fail++; $display("FAIL b3_rebub[%0d] got pc=%h fv=%b want 300 0", i, pc3, fv3);
      end
      step();
    end
    n_checks++; if (pc3 !== 32'h300 || fv3 !== 1'b1) begin n_fail++; $display("FAIL b3_target got pc=%h fv=%b want 300 1", pc3, fv3); end
    step();
    n_checks++; if (pc3 !== 32'h301 || fv3 !== 1'b1) begin n_fail++; $display("FAIL b3_next got pc=%h fv=%b want 301 1", pc3, fv3); end
    n_checks++; if (rc3 !== 16'd2) begin n_fail++; $display("FAIL b3_count got %h want 2", rc3); end
  endtask

  task automatic test_saturation();
    jump = 1'b1; jump_target = 32'h500;
    for (int i = 0; i < 65532; i++) step();
    n_checks++; if (rc3 !== 16'hFFFE || rc1 !== 16'hFFFE) begin
      n_fail++; $display("FAIL sat_pre got b3=%h b1=%h want fffe", rc3, rc1);
    end
    step();
    n_checks++; if (rc3 !== 16'hFFFF || rc1 !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_hit got b3=%h b1=%h want ffff", rc3, rc1);
    end
    for (int i = 0; i < 6; i++) step();
    n_checks++; if (rc3 !== 16'hFFFF || rc1 !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_hold got b3=%h b1=%h want ffff", rc3, rc1);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_branch();
    test_negative_and_wrap();
    test_jump_priority_stall();
    test_halt();
    test_back_to_back();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
